kplic_ctrl: RTL and testbench



---
 rtl/kplic_ctrl_pkg.sv | 19 +
 rtl/kplic_ctrl_gateway.sv | 73 +++++++
 rtl/kplic_ctrl.sv | 146 ++++++++++++++
 tb/tb_kplic_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kplic_ctrl_pkg.sv
// Shared definitions for the kplic interrupt controller: register offsets,
// source-ID width and gateway state encoding.
package kplic_ctrl_pkg;

    localparam int ID_W = 4;

    localparam logic [7:0] OFF_PENDING = 8'h40;
    localparam logic [7:0] OFF_ENABLE  = 8'h44;
    localparam logic [7:0] OFF_THRESH  = 8'h48;
    localparam logic [7:0] OFF_CLAIM   = 8'h4C;
    localparam logic [7:0] OFF_TRIG    = 8'h50;

    typedef enum logic [1:0] {
        GW_IDLE = 2'd0,
        GW_PEND = 2'd1,
        GW_INFL = 2'd2
    } gw_state_e;

endpackage

// File: rtl/kplic_ctrl_gateway.sv
// Per-source interrupt gateway: input synchronizer, edge detect and the
// IDLE/PEND/INFL lifecycle with a single held edge while in flight.
module kplic_ctrl_gateway
    import kplic_ctrl_pkg::*;
(
    input  logic cpu_clk,
    input  logic cpu_rstn,
    input  logic src_i,
    input  logic trig_i,
    input  logic claim_hit_i,
    input  logic complete_hit_i,
    output logic pend_o
);

    logic      sync1_q;
    logic      s_int_q;
    logic      s_prev_q;
    gw_state_e state_q, state_d;
    logic      held_q, held_d;
    logic      rise;
    logic      trigger;

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            sync1_q  <= 1'b0;
            s_int_q  <= 1'b0;
            s_prev_q <= 1'b0;
            state_q  <= GW_IDLE;
            held_q   <= 1'b0;
        end else begin
            sync1_q  <= src_i;
            s_int_q  <= sync1_q;
            s_prev_q <= s_int_q;
            state_q  <= state_d;
            held_q   <= held_d;
        end
    end

    assign rise    = s_int_q & ~s_prev_q;
    assign trigger = trig_i ? rise : s_int_q;

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        case (state_q)
            GW_IDLE: begin
                if (trigger) state_d = GW_PEND;
            end
            GW_PEND: begin
                // an edge coinciding with the claim must not be lost
                if (claim_hit_i) begin
                    state_d = GW_INFL;
                    held_d  = trig_i & rise;
                end
            end
            GW_INFL: begin
                if (complete_hit_i) begin
                    state_d = (held_q | trigger) ? GW_PEND : GW_IDLE;
                    held_d  = 1'b0;
                end else if (trig_i & rise) begin
                    held_d = 1'b1;
                end
            end
            default: begin
                state_d = GW_IDLE;
                held_d  = 1'b0;
            end
        endcase
    end

    assign pend_o = (state_q == GW_PEND);

endmodule

// File: rtl/kplic_ctrl.sv
// Platform-level interrupt controller: register file, priority arbitration,
// claim/complete decode and the registered interrupt request.
module kplic_ctrl
    import kplic_ctrl_pkg::*;
#(
    parameter int N_SRC  = 8,
    parameter int PRIO_W = 3
) (
    input  logic              cpu_clk,
    input  logic              cpu_rstn,
    input  logic [N_SRC-1:0]  src_int,
    input  logic              reg_sel,
    input  logic              reg_wr,
    input  logic [7:0]        reg_addr,
    input  logic [31:0]       reg_wdata,
    output logic [31:0]       reg_rdata,
    output logic              reg_ready,
    output logic              kplic_int
);

    logic [PRIO_W-1:0] prio_q [1:N_SRC];
    logic [PRIO_W-1:0] prio_d [1:N_SRC];
    logic [N_SRC:1]    enable_q, enable_d;
    logic [N_SRC:1]    trig_q, trig_d;
    logic [PRIO_W-1:0] thresh_q, thresh_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q;
    logic              int_q, int_d;

    logic [N_SRC:1]    pend;
    logic [N_SRC:1]    claim_hit;
    logic [N_SRC:1]    complete_hit;
    logic              rd_acc, wr_acc;
    logic              claim_rd, complete_wr;
    logic [ID_W-1:0]   best_id;
    logic [PRIO_W-1:0] best_prio;
    logic [PRIO_W-1:0] next_prio;
    logic              unused_wdata;

    assign rd_acc      = reg_sel & ~reg_wr;
    assign wr_acc      = reg_sel & reg_wr;
    assign claim_rd    = rd_acc & (reg_addr == OFF_CLAIM);
    assign complete_wr = wr_acc & (reg_addr == OFF_CLAIM);
    assign unused_wdata = ^reg_wdata;

    generate
        for (genvar gi = 1; gi <= N_SRC; gi++) begin : g_src
            assign claim_hit[gi]    = claim_rd & (best_id == ID_W'(gi));
            assign complete_hit[gi] = complete_wr & (reg_wdata[ID_W-1:0] == ID_W'(gi));
            assign prio_d[gi]       = (wr_acc && reg_addr == 8'(4 * gi))
                                      ? reg_wdata[PRIO_W-1:0] : prio_q[gi];

            always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
                if (!cpu_rstn) prio_q[gi] <= '0;
                else           prio_q[gi] <= prio_d[gi];
            end

            kplic_ctrl_gateway u_gw (
                .cpu_clk        (cpu_clk),
                .cpu_rstn       (cpu_rstn),
                .src_i          (src_int[gi-1]),
                .trig_i         (trig_q[gi]),
                .claim_hit_i    (claim_hit[gi]),
                .complete_hit_i (complete_hit[gi]),
                .pend_o         (pend[gi])
            );
        end
    endgenerate

    always_comb begin
        enable_d = enable_q;
        trig_d   = trig_q;
        thresh_d = thresh_q;
        if (wr_acc) begin
            case (reg_addr)
                OFF_ENABLE: enable_d = reg_wdata[N_SRC:1];
                OFF_THRESH: thresh_d = reg_wdata[PRIO_W-1:0];
                OFF_TRIG:   trig_d   = reg_wdata[N_SRC:1];
                default: ;
            endcase
        end
    end

    // Strict '>' starting from 0 excludes PRIO 0 and keeps the lowest ID on ties.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            if (pend[i] && enable_q[i] && prio_q[i] > best_prio) begin
                best_prio = prio_q[i];
                best_id   = ID_W'(i);
            end
        end
    end

    // Request for the next cycle already drops the source being claimed and
    // uses the register values being written this cycle.
    always_comb begin
        next_prio = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            if (pend[i] && !claim_hit[i] && enable_d[i] && prio_d[i] > next_prio)
                next_prio = prio_d[i];
        end
        int_d = (next_prio > thresh_d);
    end

    always_comb begin
        rdata_d = '0;
        if (rd_acc) begin
            for (int i = 1; i <= N_SRC; i++) begin
                if (reg_addr == 8'(4 * i)) rdata_d[PRIO_W-1:0] = prio_q[i];
            end
            case (reg_addr)
                OFF_PENDING: rdata_d[N_SRC:1]    = pend;
                OFF_ENABLE:  rdata_d[N_SRC:1]    = enable_q;
                OFF_THRESH:  rdata_d[PRIO_W-1:0] = thresh_q;
                OFF_CLAIM:   rdata_d[ID_W-1:0]   = best_id;
                OFF_TRIG:    rdata_d[N_SRC:1]    = trig_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            enable_q <= '0;
            trig_q   <= '0;
            thresh_q <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            int_q    <= 1'b0;
        end else begin
            enable_q <= enable_d;
            trig_q   <= trig_d;
            thresh_q <= thresh_d;
            rdata_q  <= rdata_d;
            ready_q  <= reg_sel;
            int_q    <= int_d;
        end
    end

    assign reg_rdata = rdata_q;
    assign reg_ready = ready_q;
    assign kplic_int = int_q;

endmodule

// File: tb/tb_kplic_ctrl.sv
// Bench for kplic_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all continuously checked against a behavioural model.
module tb_kplic_ctrl;

    localparam int N = 8;
    localparam int PW = 3;
    localparam int S_IDLE = 0;
    localparam int S_PEND = 1;
    localparam int S_INFL = 2;

    logic          cpu_clk;
    logic          cpu_rstn;
    logic [N-1:0]  src_int;
    logic          reg_sel;
    logic          reg_wr;
    logic [7:0]    reg_addr;
    logic [31:0]   reg_wdata;
    logic [31:0]   reg_rdata;
    logic          reg_ready;
    logic          kplic_int;

    int n_cmp = 0;
    int n_mis = 0;
    bit mon_en = 0;

    kplic_ctrl #(.N_SRC(N), .PRIO_W(PW)) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rstn  (cpu_rstn),
        .src_int   (src_int),
        .reg_sel   (reg_sel),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_ready (reg_ready),
        .kplic_int (kplic_int)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int        m_st   [1:N];
    bit        m_held [1:N];
    int        m_prio [1:N];
    bit [N:1]  m_en, m_trig;
    int        m_thresh;
    bit [N:1]  m_s1, m_s2, m_prev;
    bit        exp_int, exp_ready, exp_rd;
    logic [31:0] exp_rdata;

    int        t_best, t_bp, t_maxp, t_st, t_nth;
    int        t_np [1:N];
    bit        t_h, t_s, t_edge, t_trg, t_claimed, t_completed, t_rd, t_wr;
    bit [N:1]  t_nen, t_ntr;

    function automatic logic [31:0] model_read(input logic [7:0] a, input int best);
        logic [31:0] v;
        v = '0;
        for (int i = 1; i <= N; i++)
            if (a == 8'(4 * i)) v = 32'(m_prio[i]);
        case (a)
            8'h40: for (int i = 1; i <= N; i++) if (m_st[i] == S_PEND) v[i] = 1'b1;
            8'h44: v[N:1] = m_en;
            8'h48: v = 32'(m_thresh);
            8'h4C: v = 32'(best);
            8'h50: v[N:1] = m_trig;
            default: ;
        endcase
        return v;
    endfunction

    always @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            for (int i = 1; i <= N; i++) begin
                m_st[i]   <= S_IDLE;
                m_held[i] <= 1'b0;
                m_prio[i] <= 0;
            end
            m_en <= '0; m_trig <= '0; m_thresh <= 0;
            m_s1 <= '0; m_s2 <= '0; m_prev <= '0;
            exp_int <= 1'b0; exp_ready <= 1'b0; exp_rd <= 1'b0; exp_rdata <= '0;
        end else begin
            // highest priority pending+enabled source, lowest ID on a tie
            t_best = 0; t_bp = 0;
            for (int i = 1; i <= N; i++)
                if (m_st[i] == S_PEND && m_en[i] && m_prio[i] > t_bp) begin
                    t_bp = m_prio[i]; t_best = i;
                end
            t_rd = reg_sel && !reg_wr;
            t_wr = reg_sel && reg_wr;
            exp_ready <= reg_sel;
            exp_rd    <= t_rd;
            exp_rdata <= t_rd ? model_read(reg_addr, t_best) : 32'd0;

            t_nen = m_en; t_ntr = m_trig; t_nth = m_thresh;
            for (int i = 1; i <= N; i++) begin
                t_np[i] = m_prio[i];
                if (t_wr && reg_addr == 8'(4 * i)) t_np[i] = int'(reg_wdata[PW-1:0]);
            end
            if (t_wr && reg_addr == 8'h44) t_nen = reg_wdata[N:1];
            if (t_wr && reg_addr == 8'h48) t_nth = int'(reg_wdata[PW-1:0]);
            if (t_wr && reg_addr == 8'h50) t_ntr = reg_wdata[N:1];

            t_maxp = 0;
            for (int i = 1; i <= N; i++) begin
                t_s         = m_s2[i];
                t_edge      = t_s && !m_prev[i];
                t_trg       = m_trig[i] ? t_edge : t_s;
                t_claimed   = t_rd && reg_addr == 8'h4C && t_best == i;
                t_completed = t_wr && reg_addr == 8'h4C && int'(reg_wdata[3:0]) == i;
                t_st = m_st[i]; t_h = m_held[i];
                if (t_st == S_IDLE) begin
                    if (t_trg) t_st = S_PEND;
                end else if (t_st == S_PEND) begin
                    if (t_claimed) begin
                        t_st = S_INFL;
                        t_h  = m_trig[i] && t_edge;
                    end
                end else begin
                    if (t_completed) begin
                        t_st = (t_h || t_trg) ? S_PEND : S_IDLE;
                        t_h  = 1'b0;
                    end else if (m_trig[i] && t_edge) begin
                        t_h = 1'b1;
                    end
                end
                if (m_st[i] == S_PEND && !t_claimed && t_nen[i] && t_np[i] > t_maxp)
                    t_maxp = t_np[i];
                m_st[i]   <= t_st;
                m_held[i] <= t_h;
                m_prio[i] <= t_np[i];
            end
            m_en <= t_nen; m_trig <= t_ntr; m_thresh <= t_nth;
            exp_int <= (t_maxp > t_nth);
            m_s1 <= src_int; m_s2 <= m_s1; m_prev <= m_s2;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge cpu_clk) begin
        if (mon_en && cpu_rstn) begin
            chk("model_kplic_int", 32'(kplic_int), 32'(exp_int));
            chk("model_reg_ready", 32'(reg_ready), 32'(exp_ready));
            if (exp_rd) chk("model_reg_rdata", reg_rdata, exp_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge cpu_clk);
    endtask

    task automatic acc(input bit w, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] r);
        reg_sel = 1'b1; reg_wr = w; reg_addr = a; reg_wdata = d;
        @(negedge cpu_clk);
        reg_sel = 1'b0; reg_wr = 1'b0;
        r = reg_rdata;
        $display("access %s addr=%h wdata=%h rdata=%h int=%0d",
                 w ? "WR" : "RD", a, d, r, kplic_int);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] r;
        acc(1'b1, a, d, r);
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] r;
        acc(1'b0, a, 32'd0, r);
        chk(nm, r, exp);
    endtask

    task automatic do_reset();
        reg_sel = 1'b0; reg_wr = 1'b0;
        cpu_rstn = 1'b0;
        #1;
        chk("rst_kplic_int", 32'(kplic_int), 32'd0);
        chk("rst_reg_ready", 32'(reg_ready), 32'd0);
        chk("rst_reg_rdata", reg_rdata, 32'd0);
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu_rstn = 1'b1; src_int = '0;
        reg_sel = 1'b0; reg_wr = 1'b0; reg_addr = '0; reg_wdata = '0;
        @(negedge cpu_clk);
        do_reset();
        mon_en = 1'b1;

        // level source: basic flow and timing
        wr(8'h0C, 32'd5);
        wr(8'h44, 32'h08);
        wr(8'h48, 32'd0);
        src_int[2] = 1'b1;
        tick(3);
        chk("lvl_int_cycle3", 32'(kplic_int), 32'd0);
        tick(1);
        chk("lvl_int_cycle4", 32'(kplic_int), 32'd1);
        rd_chk("lvl_pending", 8'h40, 32'h08);
        rd_chk("lvl_claim", 8'h4C, 32'd3);
        chk("lvl_claim_deassert", 32'(kplic_int), 32'd0);
        rd_chk("lvl_pending_infl", 8'h40, 32'h00);
        wr(8'h4C, 32'd3);
        rd_chk("lvl_repend", 8'h40, 32'h08);
        chk("lvl_repend_int", 32'(kplic_int), 32'd1);
        src_int[2] = 1'b0;
        rd_chk("lvl_claim2", 8'h4C, 32'd3);
        tick(4);
        wr(8'h4C, 32'd3);
        rd_chk("lvl_idle", 8'h40, 32'h00);

        // arbitration
        src_int = '0; tick(3); do_reset();
        wr(8'h08, 32'd4);
        wr(8'h14, 32'd6);
        wr(8'h44, 32'h24);
        src_int = 8'b0001_0010;
        tick(4);
        rd_chk("arb_high", 8'h4C, 32'd5);
        wr(8'h4C, 32'd5);
        wr(8'h14, 32'd4);
        rd_chk("arb_tie", 8'h4C, 32'd2);
        wr(8'h4C, 32'd2);
        wr(8'h48, 32'd6);
        chk("arb_thresh_int", 32'(kplic_int), 32'd0);
        rd_chk("arb_thresh_claim", 8'h4C, 32'd2);

        // edge mode with held edge
        src_int = '0; tick(3); do_reset();
        wr(8'h50, 32'h02);
        wr(8'h04, 32'd3);
        wr(8'h44, 32'h02);
        src_int[0] = 1'b1; tick(2); src_int[0] = 1'b0; tick(5);
        rd_chk("edge_pend", 8'h40, 32'h02);
        rd_chk("edge_claim", 8'h4C, 32'd1);
        for (int p = 0; p < 3; p++) begin
            src_int[0] = 1'b1; tick(2); src_int[0] = 1'b0; tick(2);
        end
        tick(3);
        rd_chk("edge_infl", 8'h40, 32'h00);
        wr(8'h4C, 32'd1);
        rd_chk("edge_held_pend", 8'h40, 32'h02);
        rd_chk("edge_claim2", 8'h4C, 32'd1);
        wr(8'h4C, 32'd1);
        tick(2);
        rd_chk("edge_idle", 8'h40, 32'h00);
        chk("edge_idle_int", 32'(kplic_int), 32'd0);

        // illegal accesses
        do_reset();
        wr(8'h10, 32'd2);
        wr(8'h44, 32'h10);
        src_int[3] = 1'b1;
        tick(4);
        rd_chk("ill_claim", 8'h4C, 32'd4);
        wr(8'h4C, 32'd7);
        rd_chk("ill_still_infl", 8'h40, 32'h00);
        rd_chk("ill_unmapped", 8'h60, 32'h00);
        rd_chk("ill_empty_claim", 8'h4C, 32'd0);
        wr(8'h4C, 32'd4);
        rd_chk("ill_complete4", 8'h40, 32'h10);

        // disabled source and PRIO 0 source
        src_int = '0; tick(3); do_reset();
        wr(8'h18, 32'd2);
        wr(8'h44, 32'h80);
        src_int[5] = 1'b1; src_int[6] = 1'b1;
        tick(5);
        rd_chk("edge_case_pending", 8'h40, 32'hC0);
        chk("edge_case_int", 32'(kplic_int), 32'd0);
        rd_chk("edge_case_claim", 8'h4C, 32'd0);

        // reset while one source is INFL and another PEND
        src_int = '0; tick(3); do_reset();
        wr(8'h04, 32'd1);
        wr(8'h08, 32'd2);
        wr(8'h44, 32'h06);
        src_int = 8'h03;
        tick(4);
        rd_chk("rst_mid_claim", 8'h4C, 32'd2);
        rd_chk("rst_mid_pending", 8'h40, 32'h02);
        src_int = '0;
        tick(3);
        do_reset();
        for (int i = 1; i <= N; i++) rd_chk("rst_prio", 8'(4 * i), 32'd0);
        rd_chk("rst_pending", 8'h40, 32'd0);
        rd_chk("rst_enable", 8'h44, 32'd0);
        rd_chk("rst_thresh", 8'h48, 32'd0);
        rd_chk("rst_trig", 8'h50, 32'd0);
        rd_chk("rst_claim", 8'h4C, 32'd0);
        chk("rst_after_int", 32'(kplic_int), 32'd0);

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            int k;
            int sel;
            if (c == 1500) begin
                reg_sel = 1'b0;
                #2 cpu_rstn = 1'b0;
                @(negedge cpu_clk);
                cpu_rstn = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(0, N - 1);
                src_int[k] = ~src_int[k];
            end
            if ($urandom_range(0, 1) == 1) begin
                reg_sel = 1'b1;
                reg_wr  = 1'($urandom_range(0, 1));
                sel = $urandom_range(0, 11);
                case (sel)
                    0, 1, 2, 3: begin
                        k = $urandom_range(1, N);
                        reg_addr = 8'(4 * k);
                    end
                    4:       reg_addr = 8'h40;
                    5:       reg_addr = 8'h44;
                    6:       reg_addr = 8'h48;
                    7, 8, 9: reg_addr = 8'h4C;
                    10:      reg_addr = 8'h50;
                    default: reg_addr = 8'h60;
                endcase
                if (reg_addr == 8'h4C) reg_wdata = 32'($urandom_range(0, 15));
                else if (reg_addr == 8'h48) reg_wdata = 32'($urandom_range(0, 3));
                else reg_wdata = $urandom;
            end else begin
                reg_sel = 1'b0;
                reg_wr  = 1'b0;
            end
            @(negedge cpu_clk);
        end
        reg_sel = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
